// File: rtl/wind_lights_seq_pkg.sv
// Shared types and constants for the runway wind-indicator light bar.
// Mode and bounce-direction encodings are fixed because cur_mode is visible on the board.
package wind_lights_pkg;

    typedef enum logic [1:0] {
        CALM   = 2'b00,
        RL     = 2'b01,
        LR     = 2'b10,
        BOUNCE = 2'b11
    } mode_t;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } dir_t;

    localparam int MAX_LIGHTS = 10;

    // Even-index lights for the widest supported bar; narrower bars take the low slice.
    localparam logic [MAX_LIGHTS-1:0] EVEN_MASK_ALL = 10'b01_0101_0101;

endpackage

// File: rtl/wind_lights_seq_if.sv
// Mode select in, light bar and status out, between the board top and the sequencer.
interface wind_lights_seq_if #(
    parameter int N_LIGHTS = 3
);
    logic [1:0]          sw;
    logic [N_LIGHTS-1:0] out;
    logic                step;
    logic [1:0]          cur_mode;

    modport master (output sw, input out, input step, input cur_mode);
    modport slave  (input sw, output out, output step, output cur_mode);
endinterface

// File: rtl/wind_lights_seq_step_timer.sv
// Free-running prescaler: tick is high for one cycle out of every STEP_CYCLES.
module step_timer #(
    parameter int STEP_CYCLES = 1,
    parameter int CNT_W       = $clog2(STEP_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = (cnt_q == LAST);
        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/wind_lights_seq.sv
// N-light runway bar sequencer: CALM, RL, LR and BOUNCE patterns, one update per prescaler tick.
// A mode change on sw is only honoured on a tick and restarts the new pattern from its start value.
module wind_lights_seq
    import wind_lights_pkg::*;
#(
    parameter int N_LIGHTS    = 3,
    parameter int STEP_CYCLES = 1,
    parameter int CNT_W       = $clog2(STEP_CYCLES + 1)
) (
    input  logic              clk,
    input  logic              reset,
    wind_lights_seq_if.slave  bus
);
    localparam logic [N_LIGHTS-1:0] PAT_E  = EVEN_MASK_ALL[N_LIGHTS-1:0];
    localparam logic [N_LIGHTS-1:0] PAT_O  = ~PAT_E;
    localparam logic [N_LIGHTS-1:0] ONE_LO = {{(N_LIGHTS-1){1'b0}}, 1'b1};
    localparam logic [N_LIGHTS-1:0] ONE_HI = {1'b1, {(N_LIGHTS-1){1'b0}}};

    logic                tick;
    mode_t               sw_mode;
    mode_t               mode_q, mode_d;
    dir_t                dir_q, dir_d;
    logic [N_LIGHTS-1:0] out_q, out_d;
    logic                step_q, step_d;
    logic                fresh_q, fresh_d;

    step_timer #(
        .STEP_CYCLES (STEP_CYCLES),
        .CNT_W       (CNT_W)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    function automatic logic [N_LIGHTS-1:0] start_pat(input mode_t m);
        case (m)
            CALM:    return PAT_E;
            RL:      return ONE_LO;
            LR:      return ONE_HI;
            BOUNCE:  return ONE_LO;
            default: return PAT_E;
        endcase
    endfunction

    always_comb begin
        sw_mode = mode_t'(bus.sw);
        mode_d  = mode_q;
        dir_d   = dir_q;
        out_d   = out_q;
        fresh_d = fresh_q;
        step_d  = tick;
        if (tick) begin
            if (fresh_q || (sw_mode != mode_q)) begin
                mode_d  = sw_mode;
                out_d   = start_pat(sw_mode);
                dir_d   = UP;
                fresh_d = 1'b0;
            end else begin
                case (mode_q)
                    CALM:   out_d = (out_q == PAT_E) ? PAT_O : PAT_E;
                    RL:     out_d = {out_q[N_LIGHTS-2:0], out_q[N_LIGHTS-1]};
                    LR:     out_d = {out_q[0], out_q[N_LIGHTS-1:1]};
                    BOUNCE: begin
                        // The end light is shown once; the turn happens on the following step.
                        if (dir_q == UP) begin
                            if (out_q[N_LIGHTS-1]) begin
                                dir_d = DOWN;
                                out_d = out_q >> 1;
                            end else begin
                                out_d = out_q << 1;
                            end
                        end else begin
                            if (out_q[0]) begin
                                dir_d = UP;
                                out_d = out_q << 1;
                            end else begin
                                out_d = out_q >> 1;
                            end
                        end
                    end
                    default: begin
                        mode_d = CALM;
                        out_d  = PAT_E;
                        dir_d  = UP;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q  <= CALM;
            dir_q   <= UP;
            out_q   <= '0;
            step_q  <= 1'b0;
            fresh_q <= 1'b1;
        end else begin
            mode_q  <= mode_d;
            dir_q   <= dir_d;
            out_q   <= out_d;
            step_q  <= step_d;
            fresh_q <= fresh_d;
        end
    end

    assign bus.out      = out_q;
    assign bus.step     = step_q;
    assign bus.cur_mode = mode_q;
endmodule

// File: tb/tb_wind_lights_seq.sv
// Directed bench for wind_lights_seq: three instances (N=3/STEP=1, N=5/STEP=1, N=5/STEP=4)
// checked against hand-computed vectors, with pattern invariants checked every cycle.
module tb_wind_lights_seq;

    typedef struct {
        logic [1:0] sw;
        logic [9:0] out;
        logic       step;
        logic [1:0] mode;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic r3, r5, r5s;
    int   n_cmp = 0;
    int   n_err = 0;
    logic seen3, seen5, seen5s, prev_st5s;

    wind_lights_seq_if #(.N_LIGHTS(3)) if3 ();
    wind_lights_seq_if #(.N_LIGHTS(5)) if5 ();
    wind_lights_seq_if #(.N_LIGHTS(5)) if5s ();

    wind_lights_seq #(.N_LIGHTS(3), .STEP_CYCLES(1)) dut3  (.clk(clk), .reset(r3),  .bus(if3));
    wind_lights_seq #(.N_LIGHTS(5), .STEP_CYCLES(1)) dut5  (.clk(clk), .reset(r5),  .bus(if5));
    wind_lights_seq #(.N_LIGHTS(5), .STEP_CYCLES(4)) dut5s (.clk(clk), .reset(r5s), .bus(if5s));

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic pat_ok(input int n, input logic [9:0] o, input logic [1:0] m);
        logic [9:0] e, full;
        e = '0;
        full = '0;
        for (int i = 0; i < n; i++) begin
            full[i] = 1'b1;
            if (i % 2 == 0) e[i] = 1'b1;
        end
        if (m == 2'b00) return (o == e) || (o == (full & ~e));
        return $onehot(o);
    endfunction

    task automatic inv(input string nm, input int n, input logic rst, input logic [9:0] o,
                       input logic [1:0] m, input logic seen);
        if (!rst && o != 0) check({nm, "_pattern"}, pat_ok(n, o, m), 1);
        if (!rst && seen)   check({nm, "_nonzero"}, (o != 0), 1);
    endtask

    // One clock; outputs are sampled 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
        if (r3) seen3 = 1'b0;   else if (if3.step)  seen3 = 1'b1;
        if (r5) seen5 = 1'b0;   else if (if5.step)  seen5 = 1'b1;
        if (r5s) seen5s = 1'b0; else if (if5s.step) seen5s = 1'b1;
        inv("inv3",  3, r3,  {7'b0, if3.out},  if3.cur_mode,  seen3);
        inv("inv5",  5, r5,  {5'b0, if5.out},  if5.cur_mode,  seen5);
        inv("inv5s", 5, r5s, {5'b0, if5s.out}, if5s.cur_mode, seen5s);
        if (!r5s) check("step5s_gap", (prev_st5s && if5s.step), 0);
        prev_st5s = r5s ? 1'b0 : if5s.step;
    endtask

    vec_t v3[12];
    vec_t v5[10];

    initial begin
        v3[0]  = '{2'b00, 10'b101, 1'b1, 2'b00};
        v3[1]  = '{2'b00, 10'b010, 1'b1, 2'b00};
        v3[2]  = '{2'b00, 10'b101, 1'b1, 2'b00};
        v3[3]  = '{2'b00, 10'b010, 1'b1, 2'b00};
        v3[4]  = '{2'b01, 10'b001, 1'b1, 2'b01};
        v3[5]  = '{2'b01, 10'b010, 1'b1, 2'b01};
        v3[6]  = '{2'b01, 10'b100, 1'b1, 2'b01};
        v3[7]  = '{2'b01, 10'b001, 1'b1, 2'b01};
        v3[8]  = '{2'b10, 10'b100, 1'b1, 2'b10};
        v3[9]  = '{2'b10, 10'b010, 1'b1, 2'b10};
        v3[10] = '{2'b10, 10'b001, 1'b1, 2'b10};
        v3[11] = '{2'b10, 10'b100, 1'b1, 2'b10};

        v5[0] = '{2'b11, 10'b00001, 1'b1, 2'b11};
        v5[1] = '{2'b11, 10'b00010, 1'b1, 2'b11};
        v5[2] = '{2'b11, 10'b00100, 1'b1, 2'b11};
        v5[3] = '{2'b11, 10'b01000, 1'b1, 2'b11};
        v5[4] = '{2'b11, 10'b10000, 1'b1, 2'b11};
        v5[5] = '{2'b11, 10'b01000, 1'b1, 2'b11};
        v5[6] = '{2'b11, 10'b00100, 1'b1, 2'b11};
        v5[7] = '{2'b11, 10'b00010, 1'b1, 2'b11};
        v5[8] = '{2'b11, 10'b00001, 1'b1, 2'b11};
        v5[9] = '{2'b11, 10'b00010, 1'b1, 2'b11};

        seen3 = 1'b0; seen5 = 1'b0; seen5s = 1'b0; prev_st5s = 1'b0;
        r3 = 1'b1; r5 = 1'b1; r5s = 1'b1;
        if3.sw = 2'b00; if5.sw = 2'b00; if5s.sw = 2'b00;

        cyc();
        check("rst3_out",   {22'b0, if3.out},  0);
        check("rst3_step",  {31'b0, if3.step}, 0);
        check("rst3_mode",  {30'b0, if3.cur_mode}, 0);
        check("rst5s_out",  {27'b0, if5s.out}, 0);
        check("rst5s_step", {31'b0, if5s.step}, 0);

        // N=3: CALM, then RL, then a switch to LR that restarts the pattern.
        r3 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if3.sw = v3[i].sw;
            cyc();
            check($sformatf("d3_out[%0d]", i),  {22'b0, if3.out},      {22'b0, v3[i].out});
            check($sformatf("d3_step[%0d]", i), {31'b0, if3.step},     {31'b0, v3[i].step});
            check($sformatf("d3_mode[%0d]", i), {30'b0, if3.cur_mode}, {30'b0, v3[i].mode});
        end

        // N=5 BOUNCE over more than one full period.
        if5.sw = 2'b11;
        r5 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            check($sformatf("d5_out[%0d]", i),  {27'b0, if5.out},      {22'b0, v5[i].out});
            check($sformatf("d5_step[%0d]", i), {31'b0, if5.step},     {31'b0, v5[i].step});
            check($sformatf("d5_mode[%0d]", i), {30'b0, if5.cur_mode}, {30'b0, v5[i].mode});
        end

        // Reset while BOUNCE is heading DOWN at 01000.
        r5 = 1'b1;
        cyc();
        r5 = 1'b0;
        for (int i = 0; i < 6; i++) cyc();
        check("d5_pre_rst_out", {27'b0, if5.out}, 32'b01000);
        r5 = 1'b1;
        cyc();
        check("d5_rst_out",  {27'b0, if5.out},      0);
        check("d5_rst_step", {31'b0, if5.step},     0);
        check("d5_rst_mode", {30'b0, if5.cur_mode}, 0);
        r5 = 1'b0;
        if5.sw = 2'b11;
        cyc();
        check("d5_rel_out0",  {27'b0, if5.out},      32'b00001);
        check("d5_rel_step0", {31'b0, if5.step},     1);
        check("d5_rel_mode0", {30'b0, if5.cur_mode}, 32'b11);
        cyc();
        check("d5_rel_out1",  {27'b0, if5.out},      32'b00010);

        // N=5 with a 4-cycle step: first update on the 4th edge after release.
        if5s.sw = 2'b01;
        r5s = 1'b0;
        for (int k = 0; k < 12; k++) begin
            logic [9:0] eo;
            cyc();
            eo = (k < 3) ? 10'b0 : (k < 7) ? 10'b00001 : (k < 11) ? 10'b00010 : 10'b00100;
            check($sformatf("d5s_out[%0d]", k),  {27'b0, if5s.out},  {22'b0, eo});
            check($sformatf("d5s_step[%0d]", k), {31'b0, if5s.step}, {31'b0, (k % 4 == 3)});
        end
        cyc();
        check("d5s_hold_out", {27'b0, if5s.out}, 32'b00100);
        // A brief sw excursion between steps must not restart RL.
        if5s.sw = 2'b10;
        cyc();
        check("d5s_glitch_mode", {30'b0, if5s.cur_mode}, 32'b01);
        check("d5s_glitch_out",  {27'b0, if5s.out},      32'b00100);
        if5s.sw = 2'b01;
        cyc();
        cyc();
        check("d5s_cont_out",  {27'b0, if5s.out},      32'b01000);
        check("d5s_cont_step", {31'b0, if5s.step},     1);
        check("d5s_cont_mode", {30'b0, if5s.cur_mode}, 32'b01);
        // A held change is taken at the next step boundary.
        if5s.sw = 2'b10;
        cyc();
        cyc();
        cyc();
        check("d5s_wait_out",  {27'b0, if5s.out},      32'b01000);
        check("d5s_wait_mode", {30'b0, if5s.cur_mode}, 32'b01);
        cyc();
        check("d5s_lr_out",  {27'b0, if5s.out},      32'b10000);
        check("d5s_lr_step", {31'b0, if5s.step},     1);
        check("d5s_lr_mode", {30'b0, if5s.cur_mode}, 32'b10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
